fcb_pmu_vlp_seq: RTL

- PMU-side responder to the pin-level VLP controller.
- Receives one-cycle set requests for chip-VLP-entry and chip-wakeup and holds them as request flags.
- Sequences fabric isolation and power gating, then clears each flag when its sequence completes. The controller waits for that clear.
- Sits between the VLP pin monitor and the fabric power switch/isolation cells; drives the PMU busy indication used for config-done.

---
 rtl/fcb_pmu_pkg.sv | 19 +
 rtl/fcb_pmu_vlp_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fcb_pmu_pkg.sv
// Shared types for the PMU-side VLP sequencer.
// Holds the FSM state encoding and the encodings of the VLP status output.
package fcb_pmu_pkg;

  typedef enum logic [2:0] {
    ST_RUN  = 3'd0,
    ST_ISO  = 3'd1,
    ST_PDN  = 3'd2,
    ST_VLP  = 3'd3,
    ST_PUP  = 3'd4,
    ST_DISO = 3'd5
  } state_e;

  localparam logic [1:0] STA_RUN   = 2'b00;
  localparam logic [1:0] STA_ENTER = 2'b01;
  localparam logic [1:0] STA_VLP   = 2'b11;
  localparam logic [1:0] STA_EXIT  = 2'b10;

endpackage

// File: rtl/fcb_pmu_vlp_seq.sv
// PMU-side responder to the VLP pin controller.
// Latches VLP-entry / wakeup set pulses as request flags, sequences fabric
// isolation and power gating, then clears each flag when its sequence is done.
// Ports:
//   fcb_sys_clk, fcb_sys_rst_n        : clock, synchronous active-low reset
//   fmic_frfu_set_pmu_chip_vlp_en/wu_en : one-cycle request pulses from the pin monitor
//   frfu_sw_set_vlp_en/wu_en          : software request pulses, same effect
//   fb_pwr_ack                        : fabric power-good (1 = powered)
//   frfu_fpmu_pmu_chip_vlp_en/_wu_en  : request flags
//   fpmu_fmic_pmu_busy                : sequence in progress
//   fpmu_iso_en, fpmu_pwr_gate        : isolation enable, power switch off
//   fpmu_vlp_sta                      : 00 run, 01 entering, 11 in VLP, 10 exiting
//   fpmu_timeout_err                  : sticky power-ack timeout
module fcb_pmu_vlp_seq
  import fcb_pmu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned ACK_TIMEOUT   = 255,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       fcb_sys_clk,
  input  logic       fcb_sys_rst_n,
  input  logic       fmic_frfu_set_pmu_chip_vlp_en,
  input  logic       fmic_frfu_set_pmu_chip_wu_en,
  input  logic       frfu_sw_set_vlp_en,
  input  logic       frfu_sw_set_wu_en,
  input  logic       fb_pwr_ack,
  output logic       frfu_fpmu_pmu_chip_vlp_en,
  output logic       frfu_fpmu_pmu_chip_vlp_wu_en,
  output logic       fpmu_fmic_pmu_busy,
  output logic       fpmu_iso_en,
  output logic       fpmu_pwr_gate,
  output logic [1:0] fpmu_vlp_sta,
  output logic       fpmu_timeout_err
);

  // Terminal counts: the counter starts at 0 on state entry, so N cycles end at N-1.
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LAST    = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vlp_q, vlp_d;
  logic             wu_q, wu_d;
  logic             err_q, err_d;
  logic             vlp_clr, wu_clr, err_set;
  logic             vlp_set, wu_set;
  logic             counting;

  assign vlp_set = fmic_frfu_set_pmu_chip_vlp_en | frfu_sw_set_vlp_en;
  assign wu_set  = fmic_frfu_set_pmu_chip_wu_en  | frfu_sw_set_wu_en;

  // State register, request flags, shared counter and sticky error.
  always_ff @(posedge fcb_sys_clk) begin
    if (!fcb_sys_rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      vlp_q   <= 1'b0;
      wu_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vlp_q   <= vlp_d;
      wu_q    <= wu_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic and flag clear requests.
  always_comb begin
    state_d = state_q;
    vlp_clr = 1'b0;
    wu_clr  = 1'b0;
    err_set = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (vlp_q) begin
          state_d = ST_ISO;
        end else if (wu_q) begin
          // Already running: acknowledge the wakeup without doing anything.
          wu_clr = 1'b1;
        end
      end
      ST_ISO: begin
        if (cnt_q == SETTLE_LAST) state_d = ST_PDN;
      end
      ST_PDN: begin
        if (!fb_pwr_ack) begin
          vlp_clr = 1'b1;
          state_d = ST_VLP;
        end else if (cnt_q == ACK_LAST) begin
          // Fabric never powered down: abort entry and bring it back up.
          err_set = 1'b1;
          vlp_clr = 1'b1;
          state_d = ST_PUP;
        end
      end
      ST_VLP: begin
        if (wu_q) state_d = ST_PUP;
      end
      ST_PUP: begin
        if (fb_pwr_ack) begin
          state_d = ST_DISO;
        end else if (cnt_q == ACK_LAST) begin
          // Flag the error but keep waiting; the fabric must come back.
          err_set = 1'b1;
        end
      end
      ST_DISO: begin
        if (cnt_q == SETTLE_LAST) begin
          wu_clr  = 1'b1;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Counter reloads on every state change and saturates instead of wrapping.
  always_comb begin
    counting = (state_q == ST_ISO) || (state_q == ST_PDN) ||
               (state_q == ST_PUP) || (state_q == ST_DISO);
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (counting && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // A set pulse wins over a same-cycle clear.
  always_comb begin
    vlp_d = vlp_set | (vlp_q & ~vlp_clr);
    wu_d  = wu_set  | (wu_q  & ~wu_clr);
    err_d = err_q | err_set;
  end

  // Output decode from the state register.
  always_comb begin
    fpmu_iso_en        = 1'b0;
    fpmu_pwr_gate      = 1'b0;
    fpmu_fmic_pmu_busy = 1'b0;
    fpmu_vlp_sta       = STA_RUN;
    case (state_q)
      ST_ISO: begin
        fpmu_iso_en        = 1'b1;
        fpmu_fmic_pmu_busy = 1'b1;
        fpmu_vlp_sta       = STA_ENTER;
      end
      ST_PDN: begin
        fpmu_iso_en        = 1'b1;
        fpmu_pwr_gate      = 1'b1;
        fpmu_fmic_pmu_busy = 1'b1;
        fpmu_vlp_sta       = STA_ENTER;
      end
      ST_VLP: begin
        fpmu_iso_en   = 1'b1;
        fpmu_pwr_gate = 1'b1;
        fpmu_vlp_sta  = STA_VLP;
      end
      ST_PUP, ST_DISO: begin
        fpmu_iso_en        = 1'b1;
        fpmu_fmic_pmu_busy = 1'b1;
        fpmu_vlp_sta       = STA_EXIT;
      end
      default: ;
    endcase
  end

  assign frfu_fpmu_pmu_chip_vlp_en    = vlp_q;
  assign frfu_fpmu_pmu_chip_vlp_wu_en = wu_q;
  assign fpmu_timeout_err             = err_q;

endmodule
